// File: rtl/traffic_phase_controller.sv
// Two-road traffic phase controller with demand-driven green extension,
// fixed yellow dwell and a maintenance blink mode. All outputs are registered.
module traffic_phase_controller #(
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 30,
    parameter int YELLOW_T   = 3,
    parameter int STOP_LIMIT = 12,
    parameter int BLINK_HALF = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    input  logic       Blink_Req,
    output logic [2:0] state,
    output logic [1:0] A_light,
    output logic [1:0] B_light,
    output logic [9:0] wait_cnt
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        BLINK    = 3'd5
    } phase_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_OFF    = 2'b11;

    localparam logic [7:0] GMIN_M1  = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_M1  = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_M1   = 8'(YELLOW_T - 1);
    localparam logic [7:0] BLINK_M1 = 8'(BLINK_HALF - 1);
    localparam logic [9:0] STOP_M1  = 10'(STOP_LIMIT - 1);

    phase_t     state_reg, state_next;
    logic [7:0] timer_reg, timer_next;
    logic [9:0] wait_reg, wait_next;
    logic       blink_on_reg, blink_on_next;
    logic [7:0] blink_cnt_reg, blink_cnt_next;
    logic [1:0] light_reg [2];
    logic [1:0] light_next [2];

    // Index 0 is road A, index 1 is road B; each road's green sees the other as opposing.
    logic [1:0] demand;
    logic [1:0] green_exit;
    assign demand = {B_Traffic, A_Traffic};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_road
            localparam phase_t GREEN_S  = (gi == 0) ? A_GREEN : B_GREEN;
            localparam phase_t YELLOW_S = (gi == 0) ? A_YELLOW : B_YELLOW;

            logic own_dem, opp_dem, min_done;
            assign own_dem  = demand[gi];
            assign opp_dem  = demand[1-gi];
            assign min_done = (timer_reg >= GMIN_M1);

            assign green_exit[gi] = (timer_reg == GMAX_M1)
                                  || (min_done && opp_dem && !own_dem)
                                  || (min_done && opp_dem && (wait_reg >= STOP_M1));

            // Lamps are decoded from the next state so they change on the same edge as state.
            assign light_next[gi] = (state_next == GREEN_S)  ? LAMP_GREEN  :
                                    (state_next == YELLOW_S) ? LAMP_YELLOW :
                                    (state_next == BLINK)    ? (blink_on_next ? LAMP_YELLOW : LAMP_OFF) :
                                                               LAMP_RED;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (Blink_Req) begin
            state_next = BLINK;
        end else begin
            unique case (state_reg)
                INIT:     state_next = A_GREEN;
                A_GREEN:  if (green_exit[0]) state_next = A_YELLOW;
                A_YELLOW: if (timer_reg == YEL_M1) state_next = B_GREEN;
                B_GREEN:  if (green_exit[1]) state_next = B_YELLOW;
                B_YELLOW: if (timer_reg == YEL_M1) state_next = A_GREEN;
                BLINK:    state_next = INIT;
                default:  state_next = INIT;
            endcase
        end
    end

    always_comb begin
        timer_next     = (timer_reg == 8'hFF) ? timer_reg : timer_reg + 8'd1;
        wait_next      = 10'd0;
        blink_on_next  = 1'b1;
        blink_cnt_next = 8'd0;

        if (state_next != state_reg) begin
            timer_next = 8'd0;
        end else if (state_reg == A_GREEN && B_Traffic) begin
            wait_next = (wait_reg == 10'h3FF) ? wait_reg : wait_reg + 10'd1;
        end else if (state_reg == B_GREEN && A_Traffic) begin
            wait_next = (wait_reg == 10'h3FF) ? wait_reg : wait_reg + 10'd1;
        end

        // Blink phase runs only while staying in BLINK; entry always starts lit.
        if (state_next == BLINK && state_reg == BLINK) begin
            if (blink_cnt_reg == BLINK_M1) begin
                blink_cnt_next = 8'd0;
                blink_on_next  = !blink_on_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 8'd1;
                blink_on_next  = blink_on_reg;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg     <= INIT;
            timer_reg     <= 8'd0;
            wait_reg      <= 10'd0;
            blink_on_reg  <= 1'b1;
            blink_cnt_reg <= 8'd0;
            light_reg[0]  <= LAMP_RED;
            light_reg[1]  <= LAMP_RED;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            wait_reg      <= wait_next;
            blink_on_reg  <= blink_on_next;
            blink_cnt_reg <= blink_cnt_next;
            light_reg[0]  <= light_next[0];
            light_reg[1]  <= light_next[1];
        end
    end

    assign state    = state_reg;
    assign A_light  = light_reg[0];
    assign B_light  = light_reg[1];
    assign wait_cnt = wait_reg;

endmodule
